// File: rtl/qpu_exu_bjp_commit_if.sv
// qpu_exu_bjp_commit_if: commit, flush-redirect and predictor-update signals of the branch commit unit
interface qpu_exu_bjp_commit_if #(parameter int PC_W = 32);
  logic            cmt_i_valid;
  logic            cmt_i_ready;
  logic            cmt_i_prdt;
  logic            cmt_i_rslv;
  logic [PC_W-1:0] cmt_i_pc;
  logic [PC_W-1:0] cmt_i_imm;
  logic            flush_o_valid;
  logic            flush_o_ready;
  logic [PC_W-1:0] flush_o_pc;
  logic            upd_o_valid;
  logic [PC_W-1:0] upd_o_pc;
  logic            upd_o_taken;
  modport master (
    output cmt_i_valid, cmt_i_prdt, cmt_i_rslv, cmt_i_pc, cmt_i_imm, flush_o_ready,
    input  cmt_i_ready, flush_o_valid, flush_o_pc, upd_o_valid, upd_o_pc, upd_o_taken
  );
  modport slave (
    input  cmt_i_valid, cmt_i_prdt, cmt_i_rslv, cmt_i_pc, cmt_i_imm, flush_o_ready,
    output cmt_i_ready, flush_o_valid, flush_o_pc, upd_o_valid, upd_o_pc, upd_o_taken
  );
endinterface

// File: rtl/qpu_exu_bjp_commit.sv
// qpu_exu_bjp_commit: branch commit, mispredict flush/redirect, predictor update and statistics
module qpu_exu_bjp_commit #(
  parameter int PC_W        = 32,
  parameter int INSTR_BYTES = 4,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  qpu_exu_bjp_commit_if.slave     bus,
  input  logic                    cnt_clr,
  output logic [CNT_W-1:0]        cnt_br,
  output logic [CNT_W-1:0]        cnt_mis
);
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t            state_q, state_d;
  logic [PC_W-1:0]   flush_pc_q, flush_pc_d, upd_pc_q, upd_pc_d, target;
  logic              upd_valid_q, upd_valid_d, upd_taken_q, upd_taken_d, acc, mis;
  logic [CNT_W-1:0]  cnt_br_q, cnt_br_d, cnt_mis_q, cnt_mis_d;
  assign bus.cmt_i_ready   = state_q == IDLE;
  assign bus.flush_o_valid = state_q == FLUSH;
  assign bus.flush_o_pc    = flush_pc_q;
  assign bus.upd_o_valid   = upd_valid_q;
  assign bus.upd_o_pc      = upd_pc_q;
  assign bus.upd_o_taken   = upd_taken_q;
  assign cnt_br            = cnt_br_q;
  assign cnt_mis           = cnt_mis_q;
  // accept/mispredict decode, redirect target, next state, update pulse and saturating counters
  always_comb begin
    acc         = bus.cmt_i_valid && state_q == IDLE;
    mis         = bus.cmt_i_prdt ^ bus.cmt_i_rslv;
    target      = bus.cmt_i_pc + (bus.cmt_i_rslv ? bus.cmt_i_imm : PC_W'(INSTR_BYTES));
    state_d     = state_q == IDLE ? ((acc && mis) ? FLUSH : IDLE)
                                  : (bus.flush_o_ready ? IDLE : FLUSH);
    flush_pc_d  = (acc && mis) ? target : flush_pc_q;
    upd_valid_d = acc;
    upd_pc_d    = acc ? bus.cmt_i_pc : upd_pc_q;
    upd_taken_d = acc ? bus.cmt_i_rslv : upd_taken_q;
    cnt_br_d    = cnt_clr ? '0 : (acc && !(&cnt_br_q)) ? cnt_br_q + 1'b1 : cnt_br_q;
    cnt_mis_d   = cnt_clr ? '0 : (acc && mis && !(&cnt_mis_q)) ? cnt_mis_q + 1'b1 : cnt_mis_q;
  end
  // state registers, async-cleared so a pending redirect is dropped on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      flush_pc_q  <= '0;
      upd_valid_q <= 1'b0;
      upd_pc_q    <= '0;
      upd_taken_q <= 1'b0;
      cnt_br_q    <= '0;
      cnt_mis_q   <= '0;
    end else begin
      state_q     <= state_d;
      flush_pc_q  <= flush_pc_d;
      upd_valid_q <= upd_valid_d;
      upd_pc_q    <= upd_pc_d;
      upd_taken_q <= upd_taken_d;
      cnt_br_q    <= cnt_br_d;
      cnt_mis_q   <= cnt_mis_d;
    end
  end
endmodule

// File: tb/tb_qpu_exu_bjp_commit.sv
// tb_qpu_exu_bjp_commit: directed and randomized checks of the branch commit unit against a queue-based model
module tb_qpu_exu_bjp_commit;
  localparam int CW  = 2;
  localparam int MAX = (1 << CW) - 1;
  logic          clk = 1'b0;
  logic          rst;
  logic          cnt_clr;
  logic [CW-1:0] cnt_br, cnt_mis;
  int            n_cmp = 0;
  int            n_mis = 0;
  qpu_exu_bjp_commit_if #(.PC_W(32)) bus ();
  qpu_exu_bjp_commit #(.PC_W(32), .INSTR_BYTES(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .cnt_clr(cnt_clr), .cnt_br(cnt_br), .cnt_mis(cnt_mis)
  );
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // model: a queue of outstanding redirect targets, last update, plain saturating counts
  logic [31:0] pend[$];
  bit          m_upd_v, m_upd_t;
  logic [31:0] m_upd_pc;
  int          m_br, m_mis;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend.delete();
      m_upd_v = 0; m_upd_t = 0; m_upd_pc = '0; m_br = 0; m_mis = 0;
    end else begin
      bit acc, mis;
      acc = bus.cmt_i_valid && pend.size() == 0;
      mis = bus.cmt_i_prdt != bus.cmt_i_rslv;
      if (pend.size() != 0 && bus.flush_o_ready) void'(pend.pop_front());
      m_upd_v = acc;
      if (acc) begin
        m_upd_pc = bus.cmt_i_pc;
        m_upd_t  = bus.cmt_i_rslv;
        if (mis) pend.push_back(bus.cmt_i_rslv ? bus.cmt_i_pc + bus.cmt_i_imm : bus.cmt_i_pc + 32'd4);
      end
      m_br  = cnt_clr ? 0 : (acc && m_br < MAX) ? m_br + 1 : m_br;
      m_mis = cnt_clr ? 0 : (acc && mis && m_mis < MAX) ? m_mis + 1 : m_mis;
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("cmt_i_ready", bus.cmt_i_ready, pend.size() == 0);
      chk("flush_o_valid", bus.flush_o_valid, pend.size() != 0);
      if (pend.size() != 0) chk("flush_o_pc", bus.flush_o_pc, pend[0]);
      chk("upd_o_valid", bus.upd_o_valid, m_upd_v);
      chk("upd_o_pc", bus.upd_o_pc, m_upd_pc);
      chk("upd_o_taken", bus.upd_o_taken, m_upd_t);
      chk("cnt_br", cnt_br, m_br);
      chk("cnt_mis", cnt_mis, m_mis);
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic commit(logic v, logic p, logic r, logic [31:0] pc, logic [31:0] imm);
    bus.cmt_i_valid = v; bus.cmt_i_prdt = p; bus.cmt_i_rslv = r;
    bus.cmt_i_pc = pc; bus.cmt_i_imm = imm;
  endtask

  initial begin
    rst = 1'b1; cnt_clr = 1'b0; bus.flush_o_ready = 1'b0;
    commit(0, 0, 0, '0, '0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("reset_ready", bus.cmt_i_ready, 1);
    chk("reset_flush_valid", bus.flush_o_valid, 0);
    chk("reset_upd_pc", bus.upd_o_pc, 0);
    // correct prediction
    commit(1, 1, 1, 32'h100, 32'h20);
    cyc();
    commit(0, 0, 0, '0, '0);
    chk("cp_upd_valid", bus.upd_o_valid, 1);
    chk("cp_upd_pc", bus.upd_o_pc, 32'h100);
    chk("cp_upd_taken", bus.upd_o_taken, 1);
    chk("cp_no_flush", bus.flush_o_valid, 0);
    chk("cp_cnt_br", cnt_br, 1);
    chk("cp_cnt_mis", cnt_mis, 0);
    // mispredict not-taken, held flush
    commit(1, 1, 0, 32'h200, 32'h40);
    cyc();
    commit(0, 0, 0, '0, '0);
    chk("mnt_flush_valid", bus.flush_o_valid, 1);
    chk("mnt_flush_pc", bus.flush_o_pc, 32'h204);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("mnt_hold_ready", bus.cmt_i_ready, 0);
      chk("mnt_hold_pc", bus.flush_o_pc, 32'h204);
    end
    bus.flush_o_ready = 1'b1;
    cyc();
    bus.flush_o_ready = 1'b0;
    chk("mnt_idle_ready", bus.cmt_i_ready, 1);
    chk("mnt_idle_flush", bus.flush_o_valid, 0);
    chk("mnt_cnt_mis", cnt_mis, 1);
    // mispredict taken with address wrap
    commit(1, 0, 1, 32'hFFFF_FFF0, 32'h20);
    cyc();
    chk("wrap_flush_pc", bus.flush_o_pc, 32'h10);
    // commit arrives in the same cycle as the flush handshake
    commit(1, 1, 1, 32'h300, 32'h8);
    bus.flush_o_ready = 1'b1;
    cyc();
    bus.flush_o_ready = 1'b0;
    chk("sim_not_accepted", bus.upd_o_valid, 0);
    chk("sim_ready", bus.cmt_i_ready, 1);
    cyc();
    commit(0, 0, 0, '0, '0);
    chk("sim_upd_valid", bus.upd_o_valid, 1);
    chk("sim_upd_pc", bus.upd_o_pc, 32'h300);
    // saturation and clear
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    chk("clr_br", cnt_br, 0);
    for (int i = 0; i < 5; i++) begin
      commit(1, 0, 0, 32'h400 + 32'(i * 4), '0);
      cyc();
      chk("b2b_upd_valid", bus.upd_o_valid, 1);
    end
    commit(0, 0, 0, '0, '0);
    chk("sat_br", cnt_br, 3);
    chk("sat_mis", cnt_mis, 0);
    commit(1, 1, 0, 32'h500, '0);
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    commit(0, 0, 0, '0, '0);
    chk("clrpri_br", cnt_br, 0);
    chk("clrpri_mis", cnt_mis, 0);
    chk("clrpri_flush", bus.flush_o_valid, 1);
    // asynchronous reset while flushing
    #2 rst = 1'b1;
    #1;
    chk("arst_flush_valid", bus.flush_o_valid, 0);
    chk("arst_ready", bus.cmt_i_ready, 1);
    cyc();
    rst = 1'b0;
    cyc();
    chk("arst_post_ready", bus.cmt_i_ready, 1);
    chk("arst_post_upd", bus.upd_o_valid, 0);
    chk("arst_post_br", cnt_br, 0);
    chk("arst_post_mis", cnt_mis, 0);
    // randomized traffic checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      commit($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), $urandom, $urandom);
      bus.flush_o_ready = $urandom_range(0, 2) == 0;
      cnt_clr = $urandom_range(0, 40) == 0;
      rst = $urandom_range(0, 250) == 0;
      cyc();
    end
    rst = 1'b0;
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
